axi_rd_responder: RTL and testbench
===================================

# axi_rd_responder

Read-channel responder for the AXI master's read path: accepts one AR request at a time, generates FIXED/INCR/WRAP beat addresses, and returns data over the R channel from an internal word-addressed register memory. It is the read-side target for the master's read initiator, used on its own when the write path is not under test. A backdoor write port preloads memory.

## Interface
- size, 4: bytes per data beat; data width = size*8
- depth, 64: memory words; word index = byte address / size
- aclk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- arvalid  in  1  read address valid
- aready  out  1  read address ready
- aradd  in  size*8  read start byte address
- arlen  in  8  beats minus one
- arsize  in  3  log2 bytes per beat
- arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- rdata  out  size*8  read data (full aligned word)
- rresp  out  2  00 OKAY, 10 SLVERR
- rlast  out  1  final beat of burst
- mem_we  in  1  backdoor write enable
- mem_waddr  in  log2(depth)  backdoor word index
- mem_wdata  in  size*8  backdoor data

## Operation
- Reset: aready=0, rvalid=0, rlast=0, rresp=00, rdata=0, memory cleared to 0, FSM=IDLE; aready rises on the first clock after resetn deasserts.
- FSM IDLE: aready=1. arvalid&&aready captures aradd/arlen/arsize/arburst, loads beat 0 and enters BURST.
- FSM BURST: aready=0, rvalid=1. On rvalid&&rready with beat count < arlen: advance address, load next beat. On the handshake of beat arlen (rlast=1): go to IDLE, with rvalid=0 and aready=1 on the next cycle.
- Loaded beat: rdata = mem[addr/size], rresp=OKAY, rlast = (beat count == arlen).
- Address step = 1<<arsize.
  - FIXED: address held.
  - INCR: address += step. No 4 KB boundary check.
  - WRAP: boundary = (arlen+1)*step. Address wraps to start aligned down to the boundary when it reaches aligned_start+boundary.
- Narrow beats (arsize < log2(size)) return the full containing word. Lane selection is the master's job.
- Burst-level error: the whole burst returns SLVERR with rdata=0 and still delivers arlen+1 beats with correct rlast. Causes:
  - arsize > log2(size)
  - arburst=11
  - WRAP with arlen not in {1,3,7,15}
- Beat-level error: word index >= depth returns SLVERR with rdata=0 for that beat only.
- Backdoor write takes effect at the clock edge. A beat loaded on the same edge as a write to its word returns the old data.

## Timing
- AR handshake at edge T: rvalid=1 with beat 0 after T (first sampled by the master at T+1).
- Back-to-back beats: one beat per cycle while rready=1. Minimum burst occupancy is arlen+1 cycles.
- rvalid=1 with rready=0: rdata, rresp and rlast stay stable, and rvalid stays 1.
- Turnaround: at least one IDLE cycle between a burst's last beat and the next AR handshake.
- resetn assertion mid-burst: outputs return to reset values asynchronously, the burst is abandoned, and no partial state is retained.

## Structure
- Package axi_pkg holds:
  - burst codes BURST_FIXED/INCR/WRAP
  - response codes RESP_OKAY/RESP_SLVERR
  - FSM state typedef {IDLE, BURST}
- Submodule axi_addr_gen is combinational: (addr, arsize, arlen, arburst) -> next addr, plus wrap_legal/size_legal flags. It is reusable by the write side.
- Top holds the FSM, beat counter, captured request registers, memory array and R output registers.

## Test plan
- Preload mem[0..3]=A0,A1,A2,A3; INCR aradd=0, arlen=3, arsize=2, rready=1 -> A0..A3 on four consecutive cycles, OKAY, rlast on beat 3, aready back high the following cycle.
- WRAP aradd=0x08, arlen=3, arsize=2 -> words 2,3,0,1, rlast on 4th beat.
- FIXED aradd=0x04, arlen=2 -> mem[1] three times, then rready toggled 1,0,0,1 -> rdata held stable during stall.
- arsize=3 (size=4) with arlen=1 -> two SLVERR beats, rdata=0, rlast on beat 1; INCR from word 63 with arlen=1 -> beat 0 OKAY, beat 1 SLVERR.
- WRAP with arlen=2 -> three SLVERR beats; arburst=11 -> SLVERR for every beat.
- resetn low during beat 1 of a 4-beat INCR -> rvalid/rlast/aready 0 immediately; a new INCR after release starts cleanly at its own aradd.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-path blocks.
//   - Burst type codes as carried on arburst.
//   - Response codes as carried on rresp.
//   - Read responder FSM state type.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat address generator, shared by read and write sides.
// Ports:
//   addr       in  current beat byte address
//   arsize     in  log2 bytes per beat
//   arlen      in  beats minus one
//   arburst    in  FIXED / INCR / WRAP / reserved
//   next_addr  out byte address of the following beat
//   wrap_legal out arlen is a legal WRAP length (2, 4, 8 or 16 beats)
//   size_legal out arsize does not exceed the data bus width
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int aw            = 32,
  parameter int max_size_log2 = 2
) (
  input  logic [aw-1:0] addr,
  input  logic [2:0]    arsize,
  input  logic [7:0]    arlen,
  input  logic [1:0]    arburst,
  output logic [aw-1:0] next_addr,
  output logic          wrap_legal,
  output logic          size_legal
);

  localparam logic [aw-1:0] one_c = {{(aw-1){1'b0}}, 1'b1};

  logic [aw-1:0] step_s;
  logic [aw-1:0] bound_s;
  logic [aw-1:0] base_s;
  logic [aw-1:0] incr_s;

  // Step, wrap window and next address selection
  always_comb begin
    step_s     = one_c << arsize;
    bound_s    = ({{(aw-8){1'b0}}, arlen} + one_c) << arsize;
    // Every address of a wrap burst shares this window base, so it can be
    // derived from the current address instead of a stored start address.
    base_s     = addr & ~(bound_s - one_c);
    incr_s     = addr + step_s;
    size_legal = (arsize <= 3'(max_size_log2));
    wrap_legal = (arlen == 8'd1) || (arlen == 8'd3) ||
                 (arlen == 8'd7) || (arlen == 8'd15);
    case (arburst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = incr_s;
      BURST_WRAP: begin
        // Offset form avoids overflow of base + bound at the top of the map
        if ((incr_s - base_s) >= bound_s) begin
          next_addr = base_s;
        end else begin
          next_addr = incr_s;
        end
      end
      default:     next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI read-channel responder backed by a word-addressed register memory.
// One AR request is accepted at a time; beats are returned on the R channel.
// Ports:
//   aclk, resetn                        clock, asynchronous active-low reset
//   arvalid/aready, aradd, arlen,
//   arsize, arburst                     read address channel
//   rvalid/rready, rdata, rresp, rlast  read data channel (registered)
//   mem_we, mem_waddr, mem_wdata        backdoor memory preload
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int size  = 4,
  parameter int depth = 64
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     arvalid,
  output logic                     aready,
  input  logic [size*8-1:0]        aradd,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [size*8-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  input  logic                     mem_we,
  input  logic [$clog2(depth)-1:0] mem_waddr,
  input  logic [size*8-1:0]        mem_wdata
);

  localparam int dw  = size * 8;
  localparam int lsb = $clog2(size);
  localparam int iw  = $clog2(depth);

  rd_state_e     state_r;
  logic [dw-1:0] addr_r;
  logic [7:0]    len_r;
  logic [2:0]    size_r;
  logic [1:0]    burst_r;
  logic [7:0]    beat_r;
  logic          err_r;
  logic [dw-1:0] mem_r [depth];

  logic [dw-1:0] gen_addr_s;
  logic [2:0]    gen_size_s;
  logic [7:0]    gen_len_s;
  logic [1:0]    gen_burst_s;
  logic [dw-1:0] next_addr_s;
  logic          wrap_legal_s;
  logic          size_legal_s;
  logic          gen_err_s;
  logic [dw-1:0] ld_addr_s;
  logic          ld_err_s;
  logic          ld_last_s;
  logic [dw-1:0] word_s;
  logic [dw-1:0] ld_data_s;
  logic [1:0]    ld_resp_s;

  // Address generator sees the incoming request while idle, the captured one during a burst
  always_comb begin
    if (state_r == IDLE) begin
      gen_addr_s  = aradd;
      gen_size_s  = arsize;
      gen_len_s   = arlen;
      gen_burst_s = arburst;
    end else begin
      gen_addr_s  = addr_r;
      gen_size_s  = size_r;
      gen_len_s   = len_r;
      gen_burst_s = burst_r;
    end
  end

  axi_addr_gen #(
    .aw            (dw),
    .max_size_log2 (lsb)
  ) u_addr_gen (
    .addr       (gen_addr_s),
    .arsize     (gen_size_s),
    .arlen      (gen_len_s),
    .arburst    (gen_burst_s),
    .next_addr  (next_addr_s),
    .wrap_legal (wrap_legal_s),
    .size_legal (size_legal_s)
  );

  // Burst-level error and the address/flags of the beat to load next
  always_comb begin
    gen_err_s = !size_legal_s || (gen_burst_s == 2'b11) ||
                ((gen_burst_s == BURST_WRAP) && !wrap_legal_s);
    if (state_r == IDLE) begin
      ld_addr_s = aradd;
      ld_err_s  = gen_err_s;
      ld_last_s = (arlen == 8'd0);
    end else begin
      ld_addr_s = next_addr_s;
      ld_err_s  = err_r;
      ld_last_s = ((beat_r + 8'd1) == len_r);
    end
  end

  // Beat data lookup; errored bursts and out-of-range words return zero
  always_comb begin
    word_s = ld_addr_s >> lsb;
    if (ld_err_s || (word_s >= dw'(depth))) begin
      ld_data_s = {dw{1'b0}};
      ld_resp_s = RESP_SLVERR;
    end else begin
      ld_data_s = mem_r[ld_addr_s[lsb +: iw]];
      ld_resp_s = RESP_OKAY;
    end
  end

  // Backdoor-written memory, cleared by reset
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= {dw{1'b0}};
      end
    end else if (mem_we) begin
      mem_r[mem_waddr] <= mem_wdata;
    end
  end

  // Request capture, beat sequencing and registered R-channel outputs
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      aready  <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= {dw{1'b0}};
      addr_r  <= {dw{1'b0}};
      len_r   <= 8'd0;
      size_r  <= 3'd0;
      burst_r <= 2'b00;
      beat_r  <= 8'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (arvalid && aready) begin
            state_r <= BURST;
            aready  <= 1'b0;
            rvalid  <= 1'b1;
            addr_r  <= aradd;
            len_r   <= arlen;
            size_r  <= arsize;
            burst_r <= arburst;
            err_r   <= gen_err_s;
            beat_r  <= 8'd0;
            rdata   <= ld_data_s;
            rresp   <= ld_resp_s;
            rlast   <= ld_last_s;
          end else begin
            aready <= 1'b1;
          end
        end
        BURST: begin
          if (rready) begin
            if (rlast) begin
              state_r <= IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              aready  <= 1'b1;
            end else begin
              addr_r <= next_addr_s;
              beat_r <= beat_r + 8'd1;
              rdata  <= ld_data_s;
              rresp  <= ld_resp_s;
              rlast  <= ld_last_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          aready  <= 1'b0;
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_responder.sv
// Self-checking bench for axi_rd_responder: directed bursts followed by
// randomized bursts, checked against a burst-level memory/address model.
module tb_axi_rd_responder;

  logic        aclk = 1'b0;
  logic        resetn;
  logic        arvalid;
  logic        aready;
  logic [31:0] aradd;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;

  int          nvec = 0;
  int          nbad = 0;
  logic [31:0] model_mem [64];

  axi_rd_responder #(.size(4), .depth(64)) dut (
    .aclk      (aclk),
    .resetn    (resetn),
    .arvalid   (arvalid),
    .aready    (aready),
    .aradd     (aradd),
    .arlen     (arlen),
    .arsize    (arsize),
    .arburst   (arburst),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nbad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] d);
    @(negedge aclk);
    mem_we    = 1'b1;
    mem_waddr = 6'(idx);
    mem_wdata = d;
    @(negedge aclk);
    mem_we    = 1'b0;
    model_mem[idx] = d;
  endtask

  function automatic bit burst_bad(input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bt);
    return (sz > 3'd2) || (bt == 2'b11) ||
           ((bt == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Expected beat payload from the model memory
  task automatic expect_beat(input logic [31:0] a, input bit bad,
                             output logic [31:0] d, output logic [1:0] r);
    if (bad || (a / 4) >= 64) begin
      d = 32'd0;
      r = 2'b10;
    end else begin
      d = model_mem[a / 4];
      r = 2'b00;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,1...
  task automatic do_burst(input string name, input logic [31:0] start, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input int mode,
                          input bit wr, input int wr_idx, input logic [31:0] wr_d);
    logic [31:0] addrs [256];
    logic [31:0] edata [256];
    logic [1:0]  eresp [256];
    logic [31:0] a, step, bnd, lo;
    bit          bad, rdy;
    int          b, cyc, w, nb;
    nb   = int'(len) + 1;
    bad  = burst_bad(len, sz, bt);
    step = 32'd1 << sz;
    bnd  = 32'(nb) * step;
    lo   = start - (start % bnd);
    a    = start;
    for (int i = 0; i < nb; i++) begin
      addrs[i] = a;
      if (bt == 2'b01) begin
        a = a + step;
      end else if (bt == 2'b10) begin
        a = a + step;
        if (a >= lo + bnd) a = lo;
      end
    end
    // Beat 0 is loaded on the handshake edge, before a same-edge backdoor write lands
    expect_beat(addrs[0], bad, edata[0], eresp[0]);
    if (wr) model_mem[wr_idx] = wr_d;
    for (int i = 1; i < nb; i++) expect_beat(addrs[i], bad, edata[i], eresp[i]);

    @(negedge aclk);
    w = 0;
    while (aready !== 1'b1 && w < 8) begin
      @(negedge aclk);
      w++;
    end
    chk($sformatf("%s.aready_idle", name), {31'd0, aready}, 32'd1);
    arvalid = 1'b1;
    aradd   = start;
    arlen   = len;
    arsize  = sz;
    arburst = bt;
    if (wr) begin
      mem_we    = 1'b1;
      mem_waddr = 6'(wr_idx);
      mem_wdata = wr_d;
    end
    @(negedge aclk);
    arvalid = 1'b0;
    mem_we  = 1'b0;

    b   = 0;
    cyc = 0;
    while (b < nb && cyc < 4 * nb + 16) begin
      chk($sformatf("%s.b%0d.rvalid", name, b), {31'd0, rvalid}, 32'd1);
      chk($sformatf("%s.b%0d.rdata", name, b), rdata, edata[b]);
      chk($sformatf("%s.b%0d.rresp", name, b), {30'd0, rresp}, {30'd0, eresp[b]});
      chk($sformatf("%s.b%0d.rlast", name, b), {31'd0, rlast}, {31'd0, (b == nb - 1)});
      chk($sformatf("%s.b%0d.aready", name, b), {31'd0, aready}, 32'd0);
      case (mode)
        1:       rdy = (cyc >= 2 * nb) ? 1'b1 : ($urandom_range(0, 3) != 0);
        2:       rdy = !(cyc == 1 || cyc == 2);
        default: rdy = 1'b1;
      endcase
      rready = rdy;
      @(negedge aclk);
      if (rdy) b++;
      cyc++;
    end
    rready = 1'b0;
    chk($sformatf("%s.all_beats", name), 32'(b), 32'(nb));
    chk($sformatf("%s.rvalid_end", name), {31'd0, rvalid}, 32'd0);
    chk($sformatf("%s.aready_end", name), {31'd0, aready}, 32'd1);
  endtask

  initial begin
    resetn    = 1'b0;
    arvalid   = 1'b0;
    aradd     = 32'd0;
    arlen     = 8'd0;
    arsize    = 3'd0;
    arburst   = 2'b00;
    rready    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = 6'd0;
    mem_wdata = 32'd0;
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;

    // Reset values
    repeat (2) @(negedge aclk);
    chk("rst.aready", {31'd0, aready}, 32'd0);
    chk("rst.rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst.rlast", {31'd0, rlast}, 32'd0);
    chk("rst.rresp", {30'd0, rresp}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    resetn = 1'b1;
    #1;
    chk("rel.aready_before_edge", {31'd0, aready}, 32'd0);
    @(negedge aclk);
    chk("rel.aready_first_edge", {31'd0, aready}, 32'd1);

    // Directed bursts
    for (int i = 0; i < 4; i++) bd_write(i, 32'h000000A0 + 32'(i));
    do_burst("incr4", 32'h0, 8'd3, 3'd2, 2'b01, 0, 1'b0, 0, 32'd0);
    do_burst("wrap4", 32'h8, 8'd3, 3'd2, 2'b10, 0, 1'b0, 0, 32'd0);
    bd_write(1, 32'hCAFE_0001);
    do_burst("fixed3", 32'h4, 8'd2, 3'd2, 2'b00, 2, 1'b0, 0, 32'd0);
    do_burst("size8", 32'h0, 8'd1, 3'd3, 2'b01, 0, 1'b0, 0, 32'd0);
    bd_write(63, 32'h6363_6363);
    do_burst("word63", 32'd252, 8'd1, 3'd2, 2'b01, 0, 1'b0, 0, 32'd0);
    do_burst("wrap_len3", 32'h0, 8'd2, 3'd2, 2'b10, 0, 1'b0, 0, 32'd0);
    do_burst("reserved", 32'h0, 8'd2, 3'd2, 2'b11, 0, 1'b0, 0, 32'd0);
    bd_write(5, 32'h0DD0_0005);
    do_burst("same_edge", 32'd20, 8'd1, 3'd2, 2'b00, 0, 1'b1, 5, 32'h0E11_0005);
    do_burst("narrow", 32'd1, 8'd5, 3'd0, 2'b01, 1, 1'b0, 0, 32'd0);

    // Reset asserted while beat 1 of a 4-beat INCR is on the bus
    @(negedge aclk);
    arvalid = 1'b1;
    aradd   = 32'h0;
    arlen   = 8'd3;
    arsize  = 3'd2;
    arburst = 2'b01;
    @(negedge aclk);
    arvalid = 1'b0;
    rready  = 1'b1;
    @(negedge aclk);
    rready  = 1'b0;
    #2;
    resetn  = 1'b0;
    #1;
    chk("midrst.rvalid", {31'd0, rvalid}, 32'd0);
    chk("midrst.rlast", {31'd0, rlast}, 32'd0);
    chk("midrst.aready", {31'd0, aready}, 32'd0);
    chk("midrst.rdata", rdata, 32'd0);
    for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) bd_write(i, 32'h0000B000 + 32'(i));
    do_burst("post_rst", 32'h8, 8'd1, 3'd2, 2'b01, 0, 1'b0, 0, 32'd0);

    // Randomized bursts
    for (int i = 0; i < 16; i++) bd_write(int'($urandom_range(0, 63)), $urandom);
    for (int i = 0; i < 30; i++) begin
      logic [31:0] s;
      logic [7:0]  l;
      logic [2:0]  z;
      logic [1:0]  t;
      s = 32'($urandom_range(0, 300));
      l = 8'($urandom_range(0, 15));
      z = 3'($urandom_range(0, 3));
      t = 2'($urandom_range(0, 3));
      do_burst($sformatf("rnd%0d", i), s, l, z, t, 1,
               ($urandom_range(0, 3) == 0), int'($urandom_range(0, 63)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
